pwm_multi: RTL and testbench

//  Multi-channel, parametrised successor to the single-channel pwm generator.

---
 rtl/pwm_multi_if.sv | 26 ++
 rtl/pwm_multi.sv | 142 ++++++++++++++
 tb/tb_pwm_multi.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_multi_if.sv
// -----------------------------------------------------------------------------
// pwm_multi_if
//   Duty-load bus from the register/decoder path into pwm_multi.
//   One write per cycle: when load is high, controlInput is written to the
//   shadow duty register of channel chSel.
//
//   Signals
//     chSel        [CH_BITS-1:0]  channel addressed by the write
//     controlInput [WIDTH-1:0]    duty value (0 = off, all ones = constant on)
//     load                        level-sampled write strobe
//
//   Modports
//     master  drives the bus (decoder side / testbench)
//     slave   receives the bus (pwm_multi)
// -----------------------------------------------------------------------------
interface pwm_multi_if #(
    parameter int WIDTH   = 8,
    parameter int CH_BITS = 4
);
    logic [CH_BITS-1:0] chSel;
    logic [WIDTH-1:0]   controlInput;
    logic               load;

    modport master (output chSel, output controlInput, output load);
    modport slave  (input  chSel, input  controlInput, input  load);
endinterface

// File: rtl/pwm_multi.sv
// -----------------------------------------------------------------------------
// pwm_multi
//   CHANNELS independent PWM outputs driven from one shared prescaler and one
//   shared phase counter. Every channel has a shadow duty register written from
//   the load bus and an active duty register that drives the comparator. The
//   shadow is copied into the active register only at that channel's own period
//   boundary, so a duty change never cuts short or stretches a pulse that is
//   already running. With PHASE_STAGGER set, channel n sees the phase counter
//   shifted by n*(2**WIDTH/CHANNELS) steps, which spreads the rising edges over
//   the period.
//
//   Ports
//     masterClk    in   system clock, everything on the rising edge
//     rst          in   synchronous reset, active high
//     ctrl         bus  pwm_multi_if.slave: chSel / controlInput / load
//     pwmOut       out  [CHANNELS-1:0] registered PWM outputs
//     periodStart  out  one-cycle pulse in the first cycle of phase == 0
//     pending      out  [CHANNELS-1:0] shadow written but not yet applied
//
//   Parameters
//     PRESCALE       masterClk cycles per phase step (>= 1)
//     WIDTH          duty / phase width; period = PRESCALE * 2**WIDTH cycles
//     CHANNELS       number of outputs (1..16)
//     CH_BITS        width of chSel, 2**CH_BITS >= CHANNELS
//     PHASE_STAGGER  0: all channels aligned, 1: staggered phases
// -----------------------------------------------------------------------------
module pwm_multi #(
    parameter int PRESCALE      = 10,
    parameter int WIDTH         = 8,
    parameter int CHANNELS      = 4,
    parameter int CH_BITS       = 4,
    parameter int PHASE_STAGGER = 0
) (
    input  logic                masterClk,
    input  logic                rst,
    pwm_multi_if.slave          ctrl,
    output logic [CHANNELS-1:0] pwmOut,
    output logic                periodStart,
    output logic [CHANNELS-1:0] pending
);

    // A one-cycle prescaler still needs a one-bit register to keep the code
    // uniform; with PRESCALE == 1 it simply sits at 0 and step is always high.
    localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0]   PHASE_MAX  = {WIDTH{1'b1}};
    localparam int                 OFFSET_STEP = (2 ** WIDTH) / CHANNELS;

    // -------------------------------------------------------------------------
    // Channel phase: shared phase plus the optional per-channel offset, wrapped
    // modulo 2**WIDTH by dropping the carry.
    // -------------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] chanPhase(input logic [WIDTH-1:0] ph,
                                                   input int               n);
        logic [31:0] sum;
        sum = 32'(ph) + ((PHASE_STAGGER != 0) ? 32'(n * OFFSET_STEP) : 32'd0);
        return sum[WIDTH-1:0];
    endfunction

    // Duty compare: the all-ones duty is forced high so the 100% case has no
    // low cycle (a plain compare would drop it for the cph == max step).
    function automatic logic dutyHigh(input logic [WIDTH-1:0] cp,
                                      input logic [WIDTH-1:0] duty);
        return (duty == PHASE_MAX) || (cp < duty);
    endfunction

    logic [PRESC_W-1:0] presc;
    logic [WIDTH-1:0]   phase;
    logic               step;

    logic [WIDTH-1:0]   shadow [CHANNELS];
    logic [WIDTH-1:0]   active [CHANNELS];
    logic [WIDTH-1:0]   cph    [CHANNELS];
    logic [CHANNELS-1:0] applyNow;
    logic [CHANNELS-1:0] writeHit;
    logic [CH_BITS-1:0]  selIdx;

    assign step   = (presc == PRESC_LAST);
    assign selIdx = ctrl.chSel;

    // -------------------------------------------------------------------------
    // Stage 0: counter state -> per-channel phase, apply and write decode.
    // Channel indices at or above CHANNELS never match a writeHit bit, which is
    // how out-of-range chSel writes get dropped.
    // -------------------------------------------------------------------------
    always_comb begin
        applyNow = '0;
        writeHit = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            cph[n]      = chanPhase(phase, n);
            applyNow[n] = step && (cph[n] == PHASE_MAX);
            writeHit[n] = ctrl.load && (32'(selIdx) == 32'(n));
        end
    end

    // -------------------------------------------------------------------------
    // Stage 1: shared prescaler, phase counter and period marker.
    // -------------------------------------------------------------------------
    always_ff @(posedge masterClk) begin
        if (rst) begin
            presc       <= '0;
            phase       <= '0;
            periodStart <= 1'b0;
        end else begin
            presc       <= step ? '0 : presc + PRESC_W'(1);
            if (step) begin
                phase <= phase + WIDTH'(1);
            end
            periodStart <= step && (phase == PHASE_MAX);
        end
    end

    // -------------------------------------------------------------------------
    // Stage 1: per-channel duty registers and registered outputs.
    // The apply is written before the shadow write so that, when both land in
    // the same cycle, active takes the old shadow and pending ends up set for
    // the freshly written value.
    // -------------------------------------------------------------------------
    always_ff @(posedge masterClk) begin
        if (rst) begin
            pwmOut  <= '0;
            pending <= '0;
            for (int n = 0; n < CHANNELS; n++) begin
                shadow[n] <= '0;
                active[n] <= '0;
            end
        end else begin
            for (int n = 0; n < CHANNELS; n++) begin
                pwmOut[n] <= dutyHigh(cph[n], active[n]);
                if (applyNow[n]) begin
                    active[n]  <= shadow[n];
                    pending[n] <= 1'b0;
                end
                if (writeHit[n]) begin
                    shadow[n]  <= ctrl.controlInput;
                    pending[n] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// -----------------------------------------------------------------------------
// tb_pwm_multi
//   Two pwm_multi instances (aligned and staggered) share one load bus. A
//   cycle-count based reference model runs alongside; directed steps measure
//   high times, edge positions and pending behaviour directly.
// -----------------------------------------------------------------------------
module tb_pwm_multi;
    localparam int P   = 10;
    localparam int W   = 8;
    localparam int C   = 4;
    localparam int CB  = 4;
    localparam int STEPS = 1 << W;
    localparam int PER = P * STEPS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pwm_multi_if #(.WIDTH(W), .CH_BITS(CB)) bus ();

    logic [C-1:0] pwm0, pwm1, pend0, pend1;
    logic         ps0, ps1;

    pwm_multi #(.PRESCALE(P), .WIDTH(W), .CHANNELS(C), .CH_BITS(CB), .PHASE_STAGGER(0)) dut0 (
        .masterClk(clk), .rst(rst), .ctrl(bus),
        .pwmOut(pwm0), .periodStart(ps0), .pending(pend0));
    pwm_multi #(.PRESCALE(P), .WIDTH(W), .CHANNELS(C), .CH_BITS(CB), .PHASE_STAGGER(1)) dut1 (
        .masterClk(clk), .rst(rst), .ctrl(bus),
        .pwmOut(pwm1), .periodStart(ps1), .pending(pend1));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (time-based) ----------------
    int  mCyc;                 // cycles elapsed since reset
    int  mShadow [2][C];
    int  mActive [2][C];
    bit  mPend   [2][C];
    logic [C-1:0] ePwm [2];
    logic ePs;
    bit  modelOn = 0;
    int  mm = 0;

    function automatic int stagOff(input int inst, input int n);
        return (inst != 0) ? n * (STEPS / C) : 0;
    endfunction

    always @(posedge clk) begin
        int ph;
        int cp;
        bit stepNow;
        if (rst) begin
            mCyc = 0;
            ePs  = 1'b0;
            for (int i = 0; i < 2; i++) begin
                ePwm[i] = '0;
                for (int n = 0; n < C; n++) begin
                    mShadow[i][n] = 0; mActive[i][n] = 0; mPend[i][n] = 0;
                end
            end
        end else begin
            ph      = (mCyc / P) % STEPS;
            stepNow = (mCyc % P) == (P - 1);
            ePs     = stepNow && (ph == STEPS - 1);
            for (int i = 0; i < 2; i++) begin
                for (int n = 0; n < C; n++) begin
                    cp = (ph + stagOff(i, n)) % STEPS;
                    ePwm[i][n] = (mActive[i][n] == STEPS - 1) || (cp < mActive[i][n]);
                    if (stepNow && cp == STEPS - 1) begin
                        mActive[i][n] = mShadow[i][n];
                        mPend[i][n]   = 0;
                    end
                    if (bus.load && int'(bus.chSel) == n) begin
                        mShadow[i][n] = int'(bus.controlInput);
                        mPend[i][n]   = 1;
                    end
                end
            end
            mCyc++;
        end
    end

    always @(negedge clk) begin
        logic [C-1:0] ep0, ep1;
        for (int n = 0; n < C; n++) begin
            ep0[n] = mPend[0][n];
            ep1[n] = mPend[1][n];
        end
        if (modelOn && (pwm0 !== ePwm[0] || pwm1 !== ePwm[1] || ps0 !== ePs ||
                        ps1 !== ePs || pend0 !== ep0 || pend1 !== ep1))
            mm++;
    end

    task automatic checkModel(input string tag);
        check(tag, mm, 0);
        mm = 0;
    endtask

    // ---------------- directed helpers ----------------
    int hi0 [C];
    int hi1 [C];
    int rise1 [C];

    task automatic runCount(input int n);
        logic [C-1:0] prev;
        prev = pwm1;
        for (int c = 0; c < C; c++) begin hi0[c] = 0; hi1[c] = 0; rise1[c] = -1; end
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            for (int c = 0; c < C; c++) begin
                hi0[c] += int'(pwm0[c]);
                hi1[c] += int'(pwm1[c]);
                if (rise1[c] < 0 && pwm1[c] && !prev[c]) rise1[c] = i;
            end
            prev = pwm1;
        end
    endtask

    task automatic doLoad(input int ch, input int val);
        bus.chSel        = CB'(ch);
        bus.controlInput = W'(val);
        bus.load         = 1'b1;
        @(negedge clk);
        bus.load         = 1'b0;
    endtask

    task automatic waitPs(input string tag);
        bit seen;
        seen = 0;
        for (int k = 0; k < PER + 500 && !seen; k++) begin
            @(negedge clk);
            if (ps0) seen = 1;
        end
        check(tag, seen, 1);
    endtask

    initial begin
        int t1, h, pBefore, pAfter, psAt, sum, lag;
        rst = 1'b1;
        bus.load = 1'b0; bus.chSel = '0; bus.controlInput = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_pwm0", pwm0, 0);
        check("rst_pwm1", pwm1, 0);
        check("rst_pending", {pend1, pend0}, 0);
        check("rst_periodStart", {ps1, ps0}, 0);
        modelOn = 1;
        rst = 1'b0;

        // Idle: periodStart cadence, outputs stay low
        waitPs("ps_first");
        check("ps_first_time", mCyc, PER);
        t1 = mCyc;
        waitPs("ps_second");
        check("ps_period", mCyc - t1, PER);
        runCount(PER);
        sum = 0;
        for (int c = 0; c < C; c++) sum += hi0[c] + hi1[c];
        check("idle_high", sum, 0);
        checkModel("model_idle");

        // Quarter duty on channel 0
        doLoad(0, 'h40);
        check("pend_after_load", pend0[0], 1);
        waitPs("ps_s2");
        check("pend_applied", pend0[0], 0);
        runCount(PER);
        check("ch0_quarter_high", hi0[0], PER / 4);
        check("others_low", hi0[1] + hi0[2] + hi0[3], 0);
        checkModel("model_s2");

        // 100% then 0% on channel 1
        doLoad(1, 'hFF);
        waitPs("ps_s3a");
        runCount(PER);
        check("ch1_full_high", hi0[1], PER);
        doLoad(1, 'h00);
        waitPs("ps_s3b");
        runCount(PER);
        check("ch1_off", hi0[1], 0);
        checkModel("model_s3");

        // Mid-period duty change on channel 2
        doLoad(2, 'h80);
        waitPs("ps_s4");
        h = 0; pBefore = 0; pAfter = 1; psAt = 0;
        for (int i = 1; i <= PER; i++) begin
            @(negedge clk);
            h += int'(pwm0[2]);
            if (i == 320) begin
                bus.chSel = CB'(2); bus.controlInput = W'('h10); bus.load = 1'b1;
            end
            if (i == 321) begin
                bus.load = 1'b0;
                check("pend_mid", pend0[2], 1);
            end
            if (i == PER - 1) pBefore = int'(pend0[2]);
            if (i == PER) begin pAfter = int'(pend0[2]); psAt = int'(ps0); end
        end
        check("ch2_pulse_kept", h, PER / 2);
        check("pend_until_boundary", pBefore, 1);
        check("pend_cleared_boundary", pAfter, 0);
        check("boundary_is_periodStart", psAt, 1);
        runCount(PER);
        check("ch2_new_duty", hi0[2], 16 * P);
        checkModel("model_s4");

        // Staggered phases, all channels at quarter duty
        for (int c = 0; c < C; c++) doLoad(c, 'h40);
        waitPs("ps_s5a");
        waitPs("ps_s5b");
        runCount(PER);
        for (int c = 0; c < C; c++) begin
            lag = ((STEPS - c * (STEPS / C)) % STEPS) * P + 1;
            check($sformatf("stag_high_%0d", c), hi1[c], PER / 4);
            check($sformatf("stag_rise_%0d", c), rise1[c], lag);
        end
        check("aligned_high_total", hi0[0] + hi0[1] + hi0[2] + hi0[3], PER);
        checkModel("model_s5");

        // Out-of-range channel select is ignored
        doLoad(5, 'h77);
        check("bad_sel_pending", {pend1, pend0}, 0);
        runCount(PER);
        check("bad_sel_no_change", hi0[0] + hi0[1] + hi0[2] + hi0[3], PER);
        checkModel("model_bad_sel");

        // Reset in the middle of a pulse
        waitPs("ps_s6");
        repeat (100) @(negedge clk);
        check("pre_rst_high", pwm0[0], 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_pwm", {pwm1, pwm0}, 0);
        check("rst_mid_pending", {pend1, pend0}, 0);
        waitPs("ps_after_rst");
        runCount(PER - 1);
        sum = 0;
        for (int c = 0; c < C; c++) sum += hi0[c] + hi1[c];
        check("rst_cleared_duty", sum, 0);

        // Load in the same cycle as the apply for channel 0
        doLoad(0, 'h40);
        check("apply_cycle_ps", ps0, 1);
        check("apply_cycle_pending", pend0[0], 1);
        runCount(PER);
        check("late_apply_not_yet", hi0[0], 0);
        check("late_apply_pend_clear", pend0[0], 0);
        runCount(PER);
        check("late_apply_duty", hi0[0], PER / 4);
        checkModel("model_s6");

        // Random loads, including out-of-range selects
        for (int i = 0; i < 2 * PER; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) begin
                bus.chSel        = CB'($urandom_range(0, 7));
                bus.controlInput = W'($urandom);
                bus.load         = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
        end
        bus.load = 1'b0;
        runCount(PER);
        checkModel("model_random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
